sha_unpadder: RTL and testbench

SHA_UNPADDER -- requirements
Module: sha_unpadder

---
 rtl/sha_pkg.sv | 16 +
 rtl/sha_padder.sv | 20 ++
 rtl/sha_unpadder.sv | 128 ++++++++++++
 tb/tb_sha_unpadder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Constants and FSM state type shared by the SHA padding/unpadding blocks.
package sha_pkg;
    localparam int WORD_W      = 32;
    localparam int LEN_W       = 64;
    localparam int BLOCK_WORDS = 16;
    localparam int CNT_W       = 4;

    typedef enum logic {
        RECV = 1'b0,
        DONE = 1'b1
    } state_t;

    function automatic int round_to_words(input int bits);
        return ((bits + WORD_W - 1) / WORD_W) * WORD_W;
    endfunction
endpackage

// File: rtl/sha_padder.sv
// Single-block SHA padding: message, a '1' marker, zero fill and a 64-bit
// big-endian bit-length field.
module sha_padder
    import sha_pkg::*;
#(
    parameter int MSG_SIZE    = 96,
    parameter int PADDED_SIZE = 512
) (
    input  logic [MSG_SIZE-1:0]    message,
    output logic [PADDED_SIZE-1:0] padded
);

    always_comb begin
        padded = '0;
        padded[PADDED_SIZE-1 -: MSG_SIZE]  = message;
        padded[PADDED_SIZE-1-MSG_SIZE]     = 1'b1;
        padded[LEN_W-1:0]                  = LEN_W'(MSG_SIZE);
    end

endmodule

// File: rtl/sha_unpadder.sv
// Receives a padded 512-bit block as 16 MSB-first words, extracts the message
// and checks every non-message bit against the padding template.
//
//   state | meaning
//   RECV  | accepting words, counting 0..15, accumulating mismatch flag
//   DONE  | one-cycle done pulse, word_ready low, counter back to 0
module sha_unpadder
    import sha_pkg::*;
#(
    parameter int MSG_SIZE    = 96,
    parameter int PADDED_SIZE = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   word_in,
    input  logic                word_valid,
    output logic                word_ready,
    output logic [MSG_SIZE-1:0] message,
    output logic                pad_ok,
    output logic                done
);

    localparam int SR_W     = round_to_words(MSG_SIZE);
    localparam int SR_WORDS = SR_W / WORD_W;
    localparam logic [PADDED_SIZE-1:0] MASK = {PADDED_SIZE{1'b1}} >> MSG_SIZE;

    if (MSG_SIZE < 1 || MSG_SIZE > 447 || PADDED_SIZE != 512) begin : g_bad_params
        $fatal(1, "sha_unpadder: MSG_SIZE must be 1..447 and PADDED_SIZE must be 512");
    end

    logic [PADDED_SIZE-1:0] template;
    logic [MSG_SIZE-1:0]    zero_msg;

    assign zero_msg = '0;

    sha_padder #(
        .MSG_SIZE    (MSG_SIZE),
        .PADDED_SIZE (PADDED_SIZE)
    ) u_template (
        .message (zero_msg),
        .padded  (template)
    );

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [MSG_SIZE-1:0] message_q, message_d;
    logic               pad_ok_q, pad_ok_d;
    logic               done_q, done_d;

    logic               xfer;
    logic               mismatch;
    logic [WORD_W-1:0]  tmpl_word;
    logic [WORD_W-1:0]  mask_word;
    int                 word_top;

    assign word_ready = (state_q == RECV) && !rst;
    assign xfer       = word_valid && word_ready;

    always_comb begin
        word_top  = PADDED_SIZE - 1 - WORD_W * int'(cnt_q);
        tmpl_word = template[word_top -: WORD_W];
        mask_word = MASK[word_top -: WORD_W];
        mismatch  = |((word_in ^ tmpl_word) & mask_word);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        sr_d      = sr_q;
        message_d = message_q;
        pad_ok_d  = pad_ok_q;
        done_d    = 1'b0;
        case (state_q)
            RECV: begin
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    // Word 0 opens a new block, so the sticky flag restarts there.
                    err_d = ((cnt_q == '0) ? 1'b0 : err_q) | mismatch;
                    if (int'(cnt_q) < SR_WORDS) begin
                        sr_d = (sr_q << WORD_W) | SR_W'(word_in);
                    end
                    if (cnt_q == CNT_W'(BLOCK_WORDS - 1)) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        message_d = sr_d[SR_W-1 -: MSG_SIZE];
                        pad_ok_d  = !err_d;
                    end
                end
            end
            DONE: begin
                state_d = RECV;
                cnt_d   = '0;
            end
            default: begin
                state_d = RECV;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RECV;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            sr_q      <= '0;
            message_q <= '0;
            pad_ok_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            sr_q      <= sr_d;
            message_q <= message_d;
            pad_ok_q  <= pad_ok_d;
            done_q    <= done_d;
        end
    end

    assign message = message_q;
    assign pad_ok  = pad_ok_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sha_unpadder.sv
// Directed and randomized block streams against a rule-based reference of the
// SHA padding format.
module tb_sha_unpadder;
    localparam int MSG = 96;
    localparam int PAD = 512;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    word_in;
    logic           word_valid;
    logic           word_ready;
    logic [MSG-1:0] message;
    logic           pad_ok;
    logic           done;

    sha_unpadder #(.MSG_SIZE(MSG), .PADDED_SIZE(PAD)) dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .message    (message),
        .pad_ok     (pad_ok),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int             done_cyc_q[$];
    logic [MSG-1:0] msg_q[$];
    logic           ok_q[$];
    int             wr_low_q[$];

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cyc_q.push_back(cyc);
            msg_q.push_back(message);
            ok_q.push_back(pad_ok);
        end
        if (rst === 1'b0 && word_ready === 1'b0) wr_low_q.push_back(cyc);
    end

    int tests = 0;
    int fails = 0;
    int xfer_q[$];
    logic [PAD-1:0] bl[$];

    task automatic chk(input string tag, input logic [PAD-1:0] obs, input logic [PAD-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MSG-1:0] ref_msg(input logic [PAD-1:0] blk);
        return blk[PAD-1 -: MSG];
    endfunction

    function automatic logic ref_ok(input logic [PAD-1:0] blk);
        logic ok;
        ok = blk[PAD-1-MSG];
        for (int i = 64; i < PAD - 1 - MSG; i++) if (blk[i]) ok = 1'b0;
        if (blk[63:0] != 64'(MSG)) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [PAD-1:0] set_word(input logic [PAD-1:0] blk, input int k, input logic [31:0] w);
        logic [PAD-1:0] b;
        b = blk;
        b[PAD-1-32*k -: 32] = w;
        return b;
    endfunction

    // mode 0: valid held high, 1: valid low on alternate cycles, 2: random
    task automatic send_words(input int mode, input int nwords);
        int k = 0;
        int step = 0;
        logic v;
        logic [PAD-1:0] b;
        while (k < nwords && step < 64 * nwords) begin
            @(negedge clk);
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (step % 2 == 1) : ($urandom_range(0, 1) == 1);
            step++;
            b = bl[k / 16];
            word_valid = v;
            word_in = v ? b[PAD-1-32*(k%16) -: 32] : $urandom();
            #1;
            if (v && word_ready) begin
                xfer_q.push_back(cyc + 1);
                k++;
            end
        end
        if (k < nwords) chk("send_timeout", k, nwords);
        @(negedge clk);
        word_valid = 1'b0;
        word_in = '0;
    endtask

    task automatic check_blocks(input int d0);
        int n;
        n = bl.size();
        repeat (3) @(negedge clk);
        chk("done_count", done_cyc_q.size() - d0, n);
        for (int b = 0; b < n; b++) begin
            if (d0 + b < done_cyc_q.size() && 16 * b + 15 < xfer_q.size()) begin
                chk($sformatf("done_cycle%0d", b), done_cyc_q[d0+b], xfer_q[16*b+15]);
                chk($sformatf("message%0d", b), msg_q[d0+b], ref_msg(bl[b]));
                chk($sformatf("pad_ok%0d", b), ok_q[d0+b], ref_ok(bl[b]));
            end
        end
        chk("message_hold", message, ref_msg(bl[n-1]));
        chk("pad_ok_hold", pad_ok, ref_ok(bl[n-1]));
    endtask

    task automatic run_case(input int mode);
        int d0;
        xfer_q.delete();
        d0 = done_cyc_q.size();
        send_words(mode, 16 * bl.size());
        check_blocks(d0);
    endtask

    logic [PAD-1:0] base;
    logic [PAD-1:0] blk;
    logic [MSG-1:0] rmsg;
    int d0, w0, sel, idx;

    initial begin
        base = {32'h61626364, 32'h65666768, 32'h696A6B6C, 32'h80000000, {11{32'h0}}, 32'h00000060};
        rst = 1'b1;
        word_valid = 1'b1;
        word_in = 32'h61626364;
        repeat (3) @(negedge clk);
        chk("rst_word_ready", word_ready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pad_ok", pad_ok, 1'b0);
        chk("rst_message", message, '0);
        rst = 1'b0;
        word_valid = 1'b0;

        bl.delete(); bl.push_back(base);                            run_case(0);
        bl.delete(); bl.push_back(set_word(base, 3, 32'h0));        run_case(0);
        bl.delete(); bl.push_back(set_word(base, 15, 32'h61));      run_case(0);
        bl.delete(); bl.push_back(set_word(base, 9, 32'h100));      run_case(0);
        bl.delete(); bl.push_back(base);                            run_case(1);

        // Partial block interrupted by reset, with a transfer offered during reset.
        bl.delete(); bl.push_back(base);
        xfer_q.delete();
        d0 = done_cyc_q.size();
        send_words(0, 7);
        rst = 1'b1;
        word_valid = 1'b1;
        word_in = base[PAD-1-32*7 -: 32];
        @(negedge clk);
        chk("rst_mid_word_ready", word_ready, 1'b0);
        rst = 1'b0;
        word_valid = 1'b0;
        xfer_q.delete();
        send_words(0, 16);
        check_blocks(d0);

        // Back-to-back good then corrupted block.
        bl.delete(); bl.push_back(base); bl.push_back(set_word(base, 3, 32'h0));
        w0 = wr_low_q.size();
        d0 = done_cyc_q.size();
        run_case(0);
        if (done_cyc_q.size() >= d0 + 2) begin
            chk("b2b_spacing", done_cyc_q[d0+1] - done_cyc_q[d0], 17);
            chk("b2b_ready_low_count", wr_low_q.size() - w0, 2);
            if (wr_low_q.size() >= w0 + 2) begin
                chk("b2b_ready_low0", wr_low_q[w0], done_cyc_q[d0]);
                chk("b2b_ready_low1", wr_low_q[w0+1], done_cyc_q[d0+1]);
            end
        end

        for (int r = 0; r < 8; r++) begin
            rmsg = {$urandom(), $urandom(), $urandom()};
            blk = '0;
            blk[PAD-1 -: MSG] = rmsg;
            blk[PAD-1-MSG] = 1'b1;
            blk[63:0] = 64'(MSG);
            sel = $urandom_range(0, 2);
            if (sel == 1) begin
                idx = $urandom_range(0, PAD - 1 - MSG);
                blk[idx] = ~blk[idx];
            end else if (sel == 2) begin
                idx = $urandom_range(PAD - MSG, PAD - 1);
                blk[idx] = ~blk[idx];
            end
            bl.delete(); bl.push_back(blk);
            run_case($urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
